hamming_serial: RTL and testbench

Bit-serial Hamming distance unit with a valid/ready handshake on both sides. Accepts two WIDTH-bit words, XORs them, and counts the differing bits at one bit per clock. Returns the distance plus an equality flag. It sits downstream of the combinational exercise/encoding stage, which produces word pairs such as 8'b11000110 and 8'b11101101. It replaces that stage's unrolled for-loop popcount with a small area-cheap sequential datapath.

---
 rtl/rec_pkg.sv | 13 +
 rtl/bit_accum.sv | 34 +++
 rtl/hamming_serial.sv | 98 +++++++++
 tb/tb_hamming_serial.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rec_pkg.sv
// Shared types and defaults for the serial Hamming distance block.
// The FSM state encoding and the default operand width live here.
package rec_pkg;

    localparam int REC_WORD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } hd_state_t;

endpackage

// File: rtl/bit_accum.sv
// XOR shift register plus popcount accumulator.
// Consumes one bit from the LSB end per step.
module bit_accum #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    acc_next
);

    logic [WIDTH-1:0] xr;
    logic [CW-1:0]    acc;

    // Count including the bit consumed this cycle.
    assign acc_next = acc + CW'(xr[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr  <= '0;
            acc <= '0;
        end else if (load) begin
            xr  <= din;
            acc <= '0;
        end else if (step) begin
            xr  <= xr >> 1;
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/hamming_serial.sv
// Bit-serial Hamming distance with valid/ready on both sides.
// Fixed latency of WIDTH cycles from accept to result.
module hamming_serial
    import rec_pkg::*;
#(
    parameter int WIDTH = REC_WORD_W,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_dist,
    output logic             out_equal,
    output logic             busy
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    hd_state_t     state;
    logic [IW-1:0] idx;
    logic          load;
    logic          step;
    logic [CW-1:0] acc_next;

    assign load = (state == IDLE) && in_valid && in_ready;
    assign step = (state == SHIFT);

    bit_accum #(
        .WIDTH(WIDTH),
        .CW   (CW)
    ) u_accum (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .din     (in_a ^ in_b),
        .acc_next(acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_dist  <= '0;
            out_equal <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= SHIFT;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    // idx saturates at LAST; it is compared, never wrapped.
                    if (idx == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_dist  <= acc_next;
                        out_equal <= (acc_next == '0);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_dist  <= '0;
                        out_equal <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_dist  <= '0;
                    out_equal <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_serial.sv
// Directed bench for hamming_serial at WIDTH=8 and WIDTH=5.
// Expected distances are hand-computed constants.
module tb_hamming_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_equal, busy;
    logic [7:0] in_a, in_b;
    logic [3:0] out_dist;

    logic       v5, r5, ov5, or5, eq5, busy5;
    logic [4:0] a5, b5;
    logic [2:0] dist5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hamming_serial #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dist(out_dist), .out_equal(out_equal),
        .busy(busy)
    );

    hamming_serial #(.WIDTH(5)) u5 (
        .clk(clk), .rst(rst),
        .in_valid(v5), .in_ready(r5),
        .in_a(a5), .in_b(b5),
        .out_valid(ov5), .out_ready(or5),
        .out_dist(dist5), .out_equal(eq5),
        .busy(busy5)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Wait for out_valid; returns number of edges waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_pair(input string tag, input logic [7:0] a,
                           input logic [7:0] b, input int ed,
                           input int ee);
        int n;
        chk({tag, "_rdy"}, int'(in_ready), 1);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
        chk({tag, "_busy"}, int'(busy), 1);
        wait_valid(n);
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_dist"}, int'(out_dist), ed);
        chk({tag, "_eq"}, int'(out_equal), ee);
        chk({tag, "_nrdy"}, int'(in_ready), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ovlo"}, int'(out_valid), 0);
        chk({tag, "_dz"}, int'(out_dist), 0);
    endtask

    logic [7:0] pa [3];
    logic [7:0] pb [3];
    int rd [3];
    int rc [3];

    initial begin
        int n, k, nres, seen;
        logic acc_now;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 8'h00; in_b = 8'h00;
        v5 = 1'b0; or5 = 1'b0; a5 = 5'd0; b5 = 5'd0;
        #2;
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dist", int'(out_dist), 0);
        chk("rst_eq", int'(out_equal), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_rdy", int'(in_ready), 1);

        // C6 ^ ED = 2B -> 4 bits
        do_pair("p1", 8'b11000110, 8'b11101101, 4, 0);
        do_pair("p2", 8'hA5, 8'hA5, 0, 1);
        do_pair("p3", 8'h00, 8'hFF, 8, 0);

        // Backpressure with a new pair waiting throughout
        in_a = 8'b11000110; in_b = 8'b11101101; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 8'hA5; in_b = 8'hA5;
        wait_valid(n);
        chk("bp_lat", n, 8);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ov", int'(out_valid), 1);
            chk("bp_dist", int'(out_dist), 4);
            chk("bp_rdy", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        chk("bp_hold_dist", int'(out_dist), 4);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_idle_ov", int'(out_valid), 0);
        chk("bp_idle_rdy", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_acc2", int'(busy), 1);
        wait_valid(n);
        chk("bp2_lat", n, 8);
        chk("bp2_dist", int'(out_dist), 0);
        chk("bp2_eq", int'(out_equal), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Back-to-back, out_ready tied high
        pa[0] = 8'b11000110; pb[0] = 8'b11101101;
        pa[1] = 8'h3C;       pb[1] = 8'h3C;
        pa[2] = 8'hFF;       pb[2] = 8'h00;
        k = 0; nres = 0; out_ready = 1'b1;
        in_a = pa[0]; in_b = pb[0]; in_valid = 1'b1;
        for (int c = 0; c < 60 && nres < 3; c++) begin
            acc_now = in_valid && in_ready;
            if (out_valid) begin
                rd[nres] = int'(out_dist);
                rc[nres] = c;
                nres++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                k++;
                if (k < 3) begin
                    in_a = pa[k]; in_b = pb[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        chk("b2b_n", nres, 3);
        chk("b2b_d0", rd[0], 4);
        chk("b2b_d1", rd[1], 0);
        chk("b2b_d2", rd[2], 8);
        chk("b2b_gap1", rc[1] - rc[0], 10);
        chk("b2b_gap2", rc[2] - rc[1], 10);

        // Reset on the 3rd SHIFT cycle
        in_a = 8'hFF; in_b = 8'h00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mr_ov", int'(out_valid), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_dist", int'(out_dist), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("mr_noresult", seen, 0);
        do_pair("mr_next", 8'h0F, 8'h00, 4, 0);

        // Reset and in_valid together: nothing accepted
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("rv_busy", int'(busy), 0);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rv_busy2", int'(busy), 0);
        chk("rv_rdy", int'(in_ready), 1);

        // WIDTH = 5 instance
        chk("w5_rdy", int'(r5), 1);
        a5 = 5'b10101; b5 = 5'b01010; v5 = 1'b1;
        @(posedge clk); #1;
        v5 = 1'b0;
        n = 0;
        while (!ov5 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w5_lat", n, 5);
        chk("w5_dist", int'(dist5), 5);
        chk("w5_eq", int'(eq5), 0);
        or5 = 1'b1;
        @(posedge clk); #1;
        or5 = 1'b0;
        chk("w5_ovlo", int'(ov5), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
